// File: rtl/rtc_set_controller.sv
// rtc_set_controller: debounced set-mode front end for the RTC counters; define RTC_SET_TIMEOUT_EN to abandon an idle SEL.
module rtc_set_controller #(
    parameter int DEB_CYCLES     = 500000,
    parameter int LOAD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic       CLOCK_50,
    input  logic       aclr,
    input  logic       key_set,
    input  logic       key_next,
    input  logic [7:0] sw,
    output logic       enable,
    output logic       load_ms,
    output logic       load_s,
    output logic       load_min,
    output logic [7:0] data,
    output logic [1:0] field,
    output logic       err
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int LW = $clog2(LOAD_CYCLES + 1);

    typedef enum logic [1:0] {RUN, SEL, LOAD} state_t;

    state_t        state, state_nx;
    logic [LW-1:0] lcnt;
    logic [1:0]    keys, press;
    logic          set_p, next_p, valid, timeout;
    logic          enable_d, load_ms_d, load_s_d, load_min_d, err_d;
    logic [7:0]    data_d;
    logic [1:0]    field_d;

    assign keys = {key_next, key_set};

    for (genvar k = 0; k < 2; k++) begin : g_key
        logic          s1, s2, level;
        logic [DW-1:0] cnt;
        always_ff @(posedge CLOCK_50 or negedge aclr)
            if (!aclr) begin
                s1    <= 1'b1;
                s2    <= 1'b1;
                level <= 1'b1;
                cnt   <= '0;
            end else begin
                s1 <= keys[k];
                s2 <= s1;
                if (s2 == level) cnt <= '0;
                else if (cnt == DW'(DEB_CYCLES - 1)) begin
                    level <= s2;
                    cnt   <= '0;
                end else cnt <= cnt + 1'b1;
            end
        assign press[k] = level && !s2 && cnt == DW'(DEB_CYCLES - 1);
    end

    assign set_p  = press[0];
    assign next_p = press[1] && !press[0];
    assign valid  = sw[3:0] <= 4'd9 && sw[7:4] <= (field == 2'd0 ? 4'd9 : 4'd5);

`ifdef RTC_SET_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    always_ff @(posedge CLOCK_50 or negedge aclr)
        if (!aclr) tcnt <= '0;
        else tcnt <= (state != SEL || |press) ? '0 : tcnt + 1'b1;
    assign timeout = tcnt == TW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0 && TIMEOUT_CYCLES > 0;
`endif

    always_ff @(posedge CLOCK_50 or negedge aclr)
        if (!aclr) begin
            state    <= RUN;
            lcnt     <= '0;
            enable   <= 1'b1;
            load_ms  <= 1'b0;
            load_s   <= 1'b0;
            load_min <= 1'b0;
            data     <= 8'h00;
            field    <= 2'd0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            lcnt     <= state == LOAD ? lcnt + 1'b1 : '0;
            enable   <= enable_d;
            load_ms  <= load_ms_d;
            load_s   <= load_s_d;
            load_min <= load_min_d;
            data     <= data_d;
            field    <= field_d;
            err      <= err_d;
        end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     state_nx = set_p ? SEL : RUN;
            SEL:     state_nx = set_p && valid ? LOAD : timeout ? RUN : SEL;
            LOAD:    state_nx = lcnt == LW'(LOAD_CYCLES - 1) ? RUN : LOAD;
            default: state_nx = RUN;
        endcase
    end

    // Strobes and enable follow the next state so they are registered yet never overlap.
    always_comb begin
        field_d    = state == RUN && set_p ? 2'd0
                   : state == SEL && next_p ? (field == 2'd2 ? 2'd0 : field + 2'd1) : field;
        data_d     = state == SEL && set_p && valid ? sw : data;
        err_d      = state == SEL ? (set_p ? !valid : next_p || timeout ? 1'b0 : err) : err;
        enable_d   = state_nx == RUN;
        load_ms_d  = state_nx == LOAD && field_d == 2'd0;
        load_s_d   = state_nx == LOAD && field_d == 2'd1;
        load_min_d = state_nx == LOAD && field_d == 2'd2;
    end
endmodule

// File: tb/tb_rtc_set_controller.sv
// tb_rtc_set_controller: directed stimulus with an output-change scoreboard for rtc_set_controller.
module tb_rtc_set_controller;
    logic       clk = 1'b0;
    logic       aclr, key_set, key_next;
    logic [7:0] sw;
    logic       enable, load_ms, load_s, load_min, err;
    logic [7:0] data;
    logic [1:0] field;

    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    logic [14:0] exp_q[$];

    rtc_set_controller #(
        .DEB_CYCLES(4),
        .LOAD_CYCLES(2),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .CLOCK_50(clk),
        .aclr(aclr),
        .key_set(key_set),
        .key_next(key_next),
        .sw(sw),
        .enable(enable),
        .load_ms(load_ms),
        .load_s(load_s),
        .load_min(load_min),
        .data(data),
        .field(field),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] obs();
        return {enable, load_ms, load_s, load_min, data, field, err};
    endfunction

    function automatic logic [14:0] tup(input bit en, input bit ms, input bit s, input bit mn,
                                        input logic [7:0] d, input logic [1:0] f, input bit e);
        return {en, ms, s, mn, d, f, e};
    endfunction

    localparam logic [14:0] RST = {1'b1, 3'b000, 8'h00, 2'd0, 1'b0};

    task automatic press(input bit s, input bit n);
        key_set  = !s;
        key_next = !n;
        repeat (10) @(negedge clk);
        key_set  = 1'b1;
        key_next = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Every change of the output tuple must match the next queued expectation.
    initial begin
        logic [14:0] prev, cur, e;
        int hi;
        int idx;
        hi  = 0;
        idx = 0;
        wait (mon_en);
        prev = obs();
        forever begin
            @(negedge clk);
            cur = obs();
            if (cur[13:11] != 3'b000) begin
                checks++;
                if (cur[14]) begin
                    failures++;
                    $display("FAIL enable_during_strobe got enable=%b strobes=%b want enable=0", cur[14], cur[13:11]);
                end
            end
            if (!aclr) hi = 0;
            else if (cur[13:11] != 3'b000) hi++;
            else if (hi != 0) begin
                checks++;
                if (hi != 2) begin
                    failures++;
                    $display("FAIL strobe_len got %0d want 2", hi);
                end
                hi = 0;
            end
            if (cur != prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change[%0d] got %h want no change", idx, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        failures++;
                        $display("FAIL trace[%0d] got %h want %h", idx, cur, e);
                    end
                end
                idx++;
            end
            prev = cur;
        end
    end

    initial begin
        bit seen;
        aclr = 1'b1; key_set = 1'b1; key_next = 1'b1; sw = 8'h00;
        #2 aclr = 1'b0;
        #1;
        checks++;
        if (obs() !== RST) begin
            failures++;
            $display("FAIL reset_initial got %h want %h", obs(), RST);
        end
        repeat (3) @(negedge clk);
        aclr = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // bouncing set key, then a clean hold: exactly one entry into SEL
        exp_q.push_back(tup(0, 0, 0, 0, 8'h00, 2'd0, 0));
        for (int i = 0; i < 10; i++) begin
            key_set = i[0];
            repeat (2) @(negedge clk);
        end
        key_set = 1'b0;
        repeat (10) @(negedge clk);
        key_set = 1'b1;
        repeat (10) @(negedge clk);

        // load seconds 45
        exp_q.push_back(tup(0, 0, 0, 0, 8'h00, 2'd1, 0));
        press(0, 1);
        sw = 8'h45;
        exp_q.push_back(tup(0, 0, 1, 0, 8'h45, 2'd1, 0));
        exp_q.push_back(tup(1, 0, 0, 0, 8'h45, 2'd1, 0));
        press(1, 0);

        // invalid minutes 61, then next clears err and wraps field
        exp_q.push_back(tup(0, 0, 0, 0, 8'h45, 2'd0, 0));
        press(1, 0);
        exp_q.push_back(tup(0, 0, 0, 0, 8'h45, 2'd1, 0));
        press(0, 1);
        exp_q.push_back(tup(0, 0, 0, 0, 8'h45, 2'd2, 0));
        press(0, 1);
        sw = 8'h61;
        exp_q.push_back(tup(0, 0, 0, 0, 8'h45, 2'd2, 1));
        press(1, 0);
        exp_q.push_back(tup(0, 0, 0, 0, 8'h45, 2'd0, 0));
        press(0, 1);

        // simultaneous set+next: set wins, centiseconds 99
        sw = 8'h99;
        exp_q.push_back(tup(0, 1, 0, 0, 8'h99, 2'd0, 0));
        exp_q.push_back(tup(1, 0, 0, 0, 8'h99, 2'd0, 0));
        press(1, 1);

        // units digit out of range, then seconds boundary 59
        exp_q.push_back(tup(0, 0, 0, 0, 8'h99, 2'd0, 0));
        press(1, 0);
        sw = 8'h9A;
        exp_q.push_back(tup(0, 0, 0, 0, 8'h99, 2'd0, 1));
        press(1, 0);
        exp_q.push_back(tup(0, 0, 0, 0, 8'h99, 2'd1, 0));
        press(0, 1);
        sw = 8'h59;
        exp_q.push_back(tup(0, 0, 1, 0, 8'h59, 2'd1, 0));
        exp_q.push_back(tup(1, 0, 0, 0, 8'h59, 2'd1, 0));
        press(1, 0);

        // minutes: 60 rejected, 05 accepted with err cleared on the load edge
        exp_q.push_back(tup(0, 0, 0, 0, 8'h59, 2'd0, 0));
        press(1, 0);
        exp_q.push_back(tup(0, 0, 0, 0, 8'h59, 2'd1, 0));
        press(0, 1);
        exp_q.push_back(tup(0, 0, 0, 0, 8'h59, 2'd2, 0));
        press(0, 1);
        sw = 8'h60;
        exp_q.push_back(tup(0, 0, 0, 0, 8'h59, 2'd2, 1));
        press(1, 0);
        sw = 8'h05;
        exp_q.push_back(tup(0, 0, 0, 1, 8'h05, 2'd2, 0));
        exp_q.push_back(tup(1, 0, 0, 0, 8'h05, 2'd2, 0));
        press(1, 0);

        // idle in SEL
        exp_q.push_back(tup(0, 0, 0, 0, 8'h05, 2'd0, 0));
`ifdef RTC_SET_TIMEOUT_EN
        exp_q.push_back(tup(1, 0, 0, 0, 8'h05, 2'd0, 0));
`endif
        press(1, 0);
        repeat (60) @(negedge clk);
`ifdef RTC_SET_TIMEOUT_EN
        exp_q.push_back(tup(0, 0, 0, 0, 8'h05, 2'd0, 0));
        press(1, 0);
`endif

        // reset in the middle of a centiseconds load
        sw = 8'h30;
        exp_q.push_back(tup(0, 1, 0, 0, 8'h30, 2'd0, 0));
        exp_q.push_back(RST);
        key_set = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = load_ms;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL load_wait got load_ms=0 want 1 within 40 cycles");
        end
        #2 aclr = 1'b0;
        #1;
        checks++;
        if (obs() !== RST) begin
            failures++;
            $display("FAIL reset_midload got %h want %h", obs(), RST);
        end
        key_set = 1'b1;
        repeat (3) @(negedge clk);
        aclr = 1'b1;
        repeat (15) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
